// File: rtl/md_sequencer.sv
// -----------------------------------------------------------------------------
// md_sequencer
// Multiply/divide sequencer for the 5-stage MIPS pipeline. Accepts
// mult/multu/div/divu/mthi/mtlo from the E stage, holds the result for a fixed
// latency to model the shared multi-cycle unit, then commits it to HI/LO.
// Also produces the D-stage stall request for the hazard unit.
//
// Ports:
//   clk       in   1   rising-edge clock
//   reset_n   in   1   synchronous active-low reset
//   start     in   1   E-stage md instruction valid
//   op        in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved
//   a, b      in  32   rs / rt operands (forwarded)
//   flush     in   1   cancel the in-flight operation
//   md_use_d  in   1   D-stage instruction uses the md unit or HI/LO
//   busy      out  1   operation in flight
//   done      out  1   one-cycle pulse when mult/div result commits
//   hi, lo    out 32   HI / LO registers
//   stall_md  out  1   combinational stall request
// -----------------------------------------------------------------------------
module md_sequencer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        md_use_d,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] L_MULT = 4'(MULT_LAT);
    localparam logic [3:0] L_DIV  = 4'(DIV_LAT);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    state_t      w_state_n;
    logic [3:0]  w_cnt_n;
    logic [31:0] w_pend_hi_n;
    logic [31:0] w_pend_lo_n;
    logic [31:0] w_hi_n;
    logic [31:0] w_lo_n;
    logic        w_done_n;

    // Arithmetic datapath
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sden;
    logic        [31:0] w_uden;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;

    assign w_prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u   = {32'd0, a} * {32'd0, b};
    assign w_div_zero = (b == 32'd0);
    assign w_div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign w_sa       = $signed(a);
    // Substitute a harmless divisor in the special cases so the divider never
    // sees x/0 or INT_MIN/-1; those results are overridden below anyway.
    assign w_sden     = (w_div_zero || w_div_ovf) ? 32'sd1 : $signed(b);
    assign w_uden     = w_div_zero ? 32'd1 : b;
    assign w_sq       = w_sa / w_sden;
    assign w_sr       = w_sa % w_sden;
    assign w_uq       = a / w_uden;
    assign w_ur       = a % w_uden;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_pend_hi_n = r_pend_hi;
        w_pend_lo_n = r_pend_lo;
        w_hi_n      = r_hi;
        w_lo_n      = r_lo;
        w_done_n    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // flush beats start: a cancelled E-stage instruction must not issue
                if (start && !flush) begin
                    case (op)
                        OP_MULT: begin
                            {w_pend_hi_n, w_pend_lo_n} = w_prod_s;
                            w_cnt_n   = L_MULT;
                            w_state_n = S_RUN;
                        end
                        OP_MULTU: begin
                            {w_pend_hi_n, w_pend_lo_n} = w_prod_u;
                            w_cnt_n   = L_MULT;
                            w_state_n = S_RUN;
                        end
                        OP_DIV: begin
                            if (w_div_zero) begin
                                w_pend_lo_n = 32'hFFFF_FFFF;
                                w_pend_hi_n = a;
                            end else if (w_div_ovf) begin
                                w_pend_lo_n = 32'h8000_0000;
                                w_pend_hi_n = 32'd0;
                            end else begin
                                w_pend_lo_n = w_sq;
                                w_pend_hi_n = w_sr;
                            end
                            w_cnt_n   = L_DIV;
                            w_state_n = S_RUN;
                        end
                        OP_DIVU: begin
                            if (w_div_zero) begin
                                w_pend_lo_n = 32'hFFFF_FFFF;
                                w_pend_hi_n = a;
                            end else begin
                                w_pend_lo_n = w_uq;
                                w_pend_hi_n = w_ur;
                            end
                            w_cnt_n   = L_DIV;
                            w_state_n = S_RUN;
                        end
                        OP_MTHI: w_hi_n = a;
                        OP_MTLO: w_lo_n = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // start is ignored here; the hazard unit never issues one
                if (flush) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = 4'd0;
                end else if (r_cnt == 4'd1) begin
                    w_hi_n    = r_pend_hi;
                    w_lo_n    = r_pend_lo;
                    w_done_n  = 1'b1;
                    w_cnt_n   = 4'd0;
                    w_state_n = S_IDLE;
                end else begin
                    w_cnt_n = r_cnt - 4'd1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_pend_hi <= w_pend_hi_n;
            r_pend_lo <= w_pend_lo_n;
            r_hi      <= w_hi_n;
            r_lo      <= w_lo_n;
            r_done    <= w_done_n;
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    // Includes the issue cycle so an mfhi/mflo right behind a mult/div is held.
    assign stall_md = md_use_d & (busy | (start & ~op[2]));

endmodule

// File: tb/tb_md_sequencer.sv
// -----------------------------------------------------------------------------
// tb_md_sequencer
// Directed self-checking bench for md_sequencer (MULT_LAT=5, DIV_LAT=10).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_md_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        md_use_d;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;

    int checks = 0;
    int errors = 0;

    md_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .md_use_d (md_use_d),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .stall_md (stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Issue one op at the current falling edge, then run until busy drops.
    // Returns at the first non-busy falling edge (the done cycle for mult/div).
    task automatic do_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                         output int n_busy, output int n_done_busy, output logic t_done,
                         output logic [31:0] t_hi, output logic [31:0] t_lo);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        @(negedge clk);
        start = 1'b0;
        n_busy = 0;
        n_done_busy = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n_busy++;
            if (done) n_done_busy++;
            @(negedge clk);
        end
        t_done = done;
        t_hi   = hi;
        t_lo   = lo;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0; md_use_d = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        md_use_d = 1'b1; start = 1'b1; op = 3'd1;
        #1;
        checks++; if (stall_md !== 1'b1) begin errors++; $display("FAIL reset_stall_comb: got %b want 1", stall_md); end
        start = 1'b0; md_use_d = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_mult();
        int nb, nd; logic d; logic [31:0] h, l;
        do_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, nb, nd, d, h, l);
        checks++; if (nb !== 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", nb); end
        checks++; if (nd !== 0) begin errors++; $display("FAIL mult_done_early: got %0d want 0", nd); end
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL mult_done: got %b want 1", d); end
        checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", h); end
        checks++; if (l !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", l); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_multu();
        int nb, nd; logic d; logic [31:0] h, l;
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, nd, d, h, l);
        checks++; if (nb !== 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 5", nb); end
        checks++; if (h !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", h); end
        checks++; if (l !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", l); end
        @(negedge clk);
    endtask

    task automatic test_div();
        int nb, nd; logic d; logic [31:0] h, l;
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, nb, nd, d, h, l);
        checks++; if (nb !== 10) begin errors++; $display("FAIL div_busy_cycles: got %0d want 10", nb); end
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL div_done: got %b want 1", d); end
        checks++; if (l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", l); end
        checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", h); end
        @(negedge clk);
        do_op(3'd2, 32'd7, 32'hFFFF_FFFE, nb, nd, d, h, l);
        checks++; if (l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_divisor_lo: got %h want fffffffd", l); end
        checks++; if (h !== 32'd1) begin errors++; $display("FAIL div_neg_divisor_hi: got %h want 00000001", h); end
        @(negedge clk);
        do_op(3'd3, 32'd7, 32'd0, nb, nd, d, h, l);
        checks++; if (l !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo: got %h want ffffffff", l); end
        checks++; if (h !== 32'd7) begin errors++; $display("FAIL divu_zero_hi: got %h want 00000007", h); end
        @(negedge clk);
        do_op(3'd2, 32'h0000_0005, 32'd0, nb, nd, d, h, l);
        checks++; if (l !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_zero_lo: got %h want ffffffff", l); end
        checks++; if (h !== 32'd5) begin errors++; $display("FAIL div_zero_hi: got %h want 00000005", h); end
        @(negedge clk);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd, d, h, l);
        checks++; if (l !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", l); end
        checks++; if (h !== 32'd0) begin errors++; $display("FAIL div_ovf_hi: got %h want 00000000", h); end
        @(negedge clk);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, nb, nd, d, h, l);
        checks++; if (l !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_lo: got %h want 7ffffffc", l); end
        checks++; if (h !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h want 00000001", h); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int nb, nd; logic d; logic [31:0] h, l;
        do_op(3'd0, 32'd2, 32'd3, nb, nd, d, h, l);
        checks++; if (d !== 1'b1 || l !== 32'd6) begin errors++; $display("FAIL b2b_first: got done=%b lo=%h want done=1 lo=00000006", d, l); end
        // second op issued in the done cycle of the first
        do_op(3'd3, 32'd100, 32'd7, nb, nd, d, h, l);
        checks++; if (nb !== 10) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 10", nb); end
        checks++; if (l !== 32'd14 || h !== 32'd2) begin errors++; $display("FAIL b2b_result: got hi=%h lo=%h want hi=00000002 lo=0000000e", h, l); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int n_stall;
        md_use_d = 1'b1;
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        #1;
        checks++; if (stall_md !== 1'b1) begin errors++; $display("FAIL stall_start_cycle: got %b want 1", stall_md); end
        n_stall = 1;
        @(negedge clk);
        start = 1'b0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            if (stall_md) n_stall++;
            @(negedge clk);
            #1;
        end
        checks++; if (n_stall !== 11) begin errors++; $display("FAIL stall_cycles: got %0d want 11", n_stall); end
        checks++; if (stall_md !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL stall_done_cycle: got stall=%b done=%b want stall=0 done=1", stall_md, done); end
        md_use_d = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        #1;
        n_stall = stall_md ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (stall_md) n_stall++;
            @(negedge clk);
        end
        checks++; if (n_stall !== 0) begin errors++; $display("FAIL stall_unused: got %0d stall cycles want 0", n_stall); end
    endtask

    task automatic test_flush();
        int n_evt;
        start = 1'b1; op = 3'd4; a = 32'h1111_1111;
        @(negedge clk);
        op = 3'd5; a = 32'h2222_2222;
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin errors++; $display("FAIL flush_hilo: got hi=%h lo=%h want hi=11111111 lo=22222222", hi, lo); end
        n_evt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) n_evt++;
            @(negedge clk);
        end
        checks++; if (n_evt !== 0) begin errors++; $display("FAIL flush_no_done: got %0d busy/done cycles want 0", n_evt); end
        start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_evt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) n_evt++;
            @(negedge clk);
        end
        checks++; if (n_evt !== 0) begin errors++; $display("FAIL start_flush_accepted: got %0d busy/done cycles want 0", n_evt); end
        checks++; if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin errors++; $display("FAIL start_flush_hilo: got hi=%h lo=%h want hi=11111111 lo=22222222", hi, lo); end
    endtask

    task automatic test_mthi_mtlo();
        md_use_d = 1'b1;
        start = 1'b1; op = 3'd4; a = 32'h1234_5678;
        #1;
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b want 0", stall_md); end
        @(negedge clk);
        checks++; if (hi !== 32'h1234_5678 || busy !== 1'b0) begin errors++; $display("FAIL mthi: got hi=%h busy=%b want hi=12345678 busy=0", hi, busy); end
        op = 3'd5; a = 32'h9ABC_DEF0;
        #1;
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL mtlo_stall: got %b want 0", stall_md); end
        @(negedge clk);
        start = 1'b0; md_use_d = 1'b0;
        checks++; if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo: got hi=%h lo=%h want hi=12345678 lo=9abcdef0", hi, lo); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_flags: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_start_during_run();
        int nb;
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            nb++;
            if (nb == 2) begin
                start = 1'b1; op = 3'd3; a = 32'd7; b = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (nb !== 5) begin errors++; $display("FAIL run_start_busy: got %0d want 5", nb); end
        checks++; if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd6) begin errors++; $display("FAIL run_start_result: got done=%b hi=%h lo=%h want 1 00000000 00000006", done, hi, lo); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_start_latent: got busy=%b want 0", busy); end
    endtask

    task automatic test_reserved();
        start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; b = 32'd1;
        @(negedge clk);
        op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin errors++; $display("FAIL reserved: got busy=%b hi=%h lo=%h want 0 00000000 00000006", busy, hi, lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reserved_done: got %b want 0", done); end
    endtask

    task automatic test_reset_mid_run();
        int n_evt;
        start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrun_reset_flags: got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midrun_reset_hilo: got hi=%h lo=%h want 0 0", hi, lo); end
        n_evt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) n_evt++;
            @(negedge clk);
        end
        checks++; if (n_evt !== 0) begin errors++; $display("FAIL midrun_reset_done: got %0d busy/done cycles want 0", n_evt); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_back_to_back();
        test_stall();
        test_flush();
        test_mthi_mtlo();
        test_start_during_run();
        test_reserved();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide sequencer for the 5-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo from the E stage and models the fixed multi-cycle latency of the shared multiply/divide resource. It owns the HI/LO registers and tells the hazard unit when the D-stage instruction must stall because the resource is busy. It sits beside the E-stage ALU; its HI/LO outputs feed the mfhi/mflo result mux.

## Interface
Parameters:
- MULT_LAT, 5: cycles from accepted mult/multu to HI/LO valid (1..15).
- DIV_LAT, 10: cycles from accepted div/divu to HI/LO valid (1..15).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  E-stage md instruction valid this cycle.
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved.
- a  in  32  rs operand (forwarded E value).
- b  in  32  rt operand (forwarded E value).
- flush  in  1  cancel the in-flight operation (exception/interrupt at M).
- md_use_d  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO just committed by mult/div.
- hi  out  32  HI register.
- lo  out  32  LO register.
- stall_md  out  1  combinational stall request to hazard unit.

## Operation
- State: IDLE, RUN. Registers: cnt[3:0], pend_hi, pend_lo, hi, lo, done.
- IDLE + start + op 0..3 + !flush: compute result into pend_hi/pend_lo at this edge; cnt <= MULT_LAT or DIV_LAT; go RUN.
- mult: signed 32x32 -> 64, {pend_hi, pend_lo} = product. multu: unsigned.
- div: pend_lo = signed quotient truncated toward zero, pend_hi = remainder with sign of a. divu: unsigned.
- Divide by zero (b==0), both div and divu: pend_lo = 32'hFFFFFFFF, pend_hi = a.
- Signed overflow (a==32'h80000000, b==32'hFFFFFFFF, div): pend_lo = 32'h80000000, pend_hi = 0.
- IDLE + start + op 4: hi <= a this edge; op 5: lo <= a; no RUN, busy stays 0, no done.
- Reserved op: ignored, no state change.
- RUN: cnt decrements each edge; on edge with cnt==1: hi <= pend_hi, lo <= pend_lo, done <= 1, go IDLE.
- start while RUN: ignored (hazard unit guarantees it cannot occur; bench checks it is harmless).
- flush in RUN: go IDLE, cnt <= 0, hi/lo unchanged, no done. flush in IDLE with start: start ignored (flush wins).
- busy = (state==RUN). stall_md = md_use_d & (busy | (start & op<=3)).

## Timing
- Reset (reset_n==0 at edge): state IDLE, cnt 0, hi 0, lo 0, done 0, pend regs 0; busy 0. stall_md follows its inputs combinationally.
- start sampled at edge t0 (op 0..3): busy high in cycles t0+1 .. t0+LAT; at edge t0+LAT HI/LO update; cycle t0+LAT+1: busy 0, done 1, new hi/lo visible.
- done is high for exactly one cycle; deasserts next edge unconditionally.
- Back-to-back: a new start is accepted in the same cycle done is high (state already IDLE).
- mthi/mtlo: visible on hi/lo the cycle after the start edge; no stall generated.
- stall_md covers the start cycle itself so a D-stage mfhi/mflo immediately behind a mult is held.
- reset_n low mid-RUN: abort as reset, no done, hi/lo cleared.
- LAT=1: busy high one cycle, commit at next edge.

## Test plan
- Reset, then mult a=0xFFFFFFFE b=0x00000003 -> busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA, done pulse 1 cycle.
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE lo=0x00000001.
- div a=0xFFFFFFF9 (-7) b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7 b=0 -> lo=0xFFFFFFFF hi=7; div 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
- md_use_d=1 held across a div: stall_md=1 from start cycle through last busy cycle (11 cycles), 0 in the done cycle; with md_use_d=0 stall_md=0 throughout.
- div running, flush at cycle 4 -> busy 0 next cycle, hi/lo keep prior values, no done; start+flush same cycle -> nothing accepted.
- mthi a=0x12345678 then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated next cycle each, busy never 1; start during RUN ignored, original result committed.
